// File: rtl/w_grf_writer_pkg.sv
// w_grf_writer_pkg -- shared definitions for the GRF write arbiter.
//   DEFAULT_DEPTH : default pending-write FIFO depth (power of 2, >= 2)
//   wgw_entry_t   : one pending write {live, a3, wd, pc}
//   GRF_TRACE_FMT : format string for the optional write trace
//                   (compiled only with GRF_WRITER_TRACE_EN defined)
`ifndef GRF_TRACE_FMT
`define GRF_TRACE_FMT "@%h: $%d <= %h"
`endif

package w_grf_writer_pkg;
  localparam int DEFAULT_DEPTH = 2;

  typedef struct packed {
    logic        live;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wgw_entry_t;
endpackage

// File: rtl/w_grf_writer_if.sv
// w_grf_writer_if -- bundle of the writer's data-path signals.
//   wb_*      : in-order write-back result
//   md_*      : late multi-cycle (MDU) result, md_ready back-pressure
//   q_a*/q_busy* : D-stage pending-write query
//   grf_*     : registered GRF write port (grf_a3==0 -> no write)
//   fifo_cnt  : stored FIFO entries (live or killed)
// slave = the writer, master = the pipeline driving it.
interface w_grf_writer_if
  import w_grf_writer_pkg::*;
#(parameter int DEPTH = DEFAULT_DEPTH);
  logic                     wb_valid;
  logic [4:0]               wb_a3;
  logic [31:0]              wb_wd, wb_pc;
  logic                     md_valid, md_ready;
  logic [4:0]               md_a3;
  logic [31:0]              md_wd, md_pc;
  logic [4:0]               q_a1, q_a2;
  logic                     q_busy1, q_busy2;
  logic [4:0]               grf_a3;
  logic [31:0]              grf_wd, grf_pc;
  logic [$clog2(DEPTH):0]   fifo_cnt;

  modport master (
    output wb_valid, wb_a3, wb_wd, wb_pc, md_valid, md_a3, md_wd, md_pc, q_a1, q_a2,
    input  md_ready, q_busy1, q_busy2, grf_a3, grf_wd, grf_pc, fifo_cnt
  );
  modport slave (
    input  wb_valid, wb_a3, wb_wd, wb_pc, md_valid, md_a3, md_wd, md_pc, q_a1, q_a2,
    output md_ready, q_busy1, q_busy2, grf_a3, grf_wd, grf_pc, fifo_cnt
  );
endinterface

// File: rtl/w_grf_writer_fifo.sv
// wgw_fifo -- pending-write storage for late MDU results.
//   clk, reset          : clock, synchronous active-high reset
//   i_push, i_push_*    : enqueue a live entry (ignored when full)
//   i_pop               : dequeue the head (ignored when empty)
//   i_kill_en/i_kill_a3 : clear live on every stored entry with a3==i_kill_a3
//   i_q_a1/2, o_q_busy1/2 : live-entry match query (combinational)
//   o_head, o_cnt       : head entry, stored entry count
module wgw_fifo
  import w_grf_writer_pkg::*;
#(parameter int DEPTH = DEFAULT_DEPTH) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [4:0]             i_push_a3,
  input  logic [31:0]            i_push_wd,
  input  logic [31:0]            i_push_pc,
  input  logic                   i_pop,
  input  logic                   i_kill_en,
  input  logic [4:0]             i_kill_a3,
  input  logic [4:0]             i_q_a1,
  input  logic [4:0]             i_q_a2,
  output logic                   o_q_busy1,
  output logic                   o_q_busy2,
  output wgw_entry_t             o_head,
  output logic [$clog2(DEPTH):0] o_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wgw_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign w_push = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop  = i_pop  && (r_cnt != '0);

  // Pointers are PW bits wide, so DEPTH being a power of 2 gives free wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill_en && r_mem[i].live && (r_mem[i].a3 == i_kill_a3))
          r_mem[i].live <= 1'b0;
      // Freed slots are marked dead so the match query only sees stored entries.
      if (w_pop) begin
        r_mem[r_rd].live <= 1'b0;
        r_rd             <= r_rd + 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr] <= '{live: 1'b1, a3: i_push_a3, wd: i_push_wd, pc: i_push_pc};
        r_wr        <= r_wr + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_comb begin
    o_q_busy1 = 1'b0;
    o_q_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].live && (r_mem[i].a3 == i_q_a1) && (i_q_a1 != 5'd0)) o_q_busy1 = 1'b1;
      if (r_mem[i].live && (r_mem[i].a3 == i_q_a2) && (i_q_a2 != 5'd0)) o_q_busy2 = 1'b1;
    end
  end

  assign o_head = r_mem[r_rd];
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/w_grf_writer.sv
// w_grf_writer -- merges in-order write-back and late MDU results into the
// single GRF write port. wb always wins; MDU results wait in wgw_fifo and are
// drained on cycles without a wb write.
//   clk, reset : clock, synchronous active-high reset
//   bus        : w_grf_writer_if.slave (wb_*, md_*, q_*, grf_*, fifo_cnt)
// Optional: define GRF_WRITER_TRACE_EN to print every committed GRF write.
module w_grf_writer
  import w_grf_writer_pkg::*;
#(parameter int DEPTH = DEFAULT_DEPTH) (
  input  logic           clk,
  input  logic           reset,
  w_grf_writer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_wb_wr, w_push, w_pop, w_rdy;
  wgw_entry_t    w_head;
  logic [CW-1:0] w_cnt;
  logic [4:0]    w_nxt_a3, r_grf_a3;
  logic [31:0]   w_nxt_wd, w_nxt_pc, r_grf_wd, r_grf_pc;

  assign w_rdy   = w_cnt < CW'(DEPTH);
  assign w_wb_wr = bus.wb_valid && (bus.wb_a3 != 5'd0);
  // md with a3==0, or targeting the register wb writes now, is accepted but
  // never stored: the wb value is already the younger one.
  assign w_push  = bus.md_valid && w_rdy && !reset && (bus.md_a3 != 5'd0) &&
                   !(w_wb_wr && (bus.md_a3 == bus.wb_a3));
  assign w_pop   = !w_wb_wr && (w_cnt != '0);

  wgw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_push_a3 (bus.md_a3),
    .i_push_wd (bus.md_wd),
    .i_push_pc (bus.md_pc),
    .i_pop     (w_pop),
    .i_kill_en (w_wb_wr),
    .i_kill_a3 (bus.wb_a3),
    .i_q_a1    (bus.q_a1),
    .i_q_a2    (bus.q_a2),
    .o_q_busy1 (bus.q_busy1),
    .o_q_busy2 (bus.q_busy2),
    .o_head    (w_head),
    .o_cnt     (w_cnt)
  );

  // A killed head is still popped but produces an all-zero (no-write) slot.
  always_comb begin
    w_nxt_a3 = '0;
    w_nxt_wd = '0;
    w_nxt_pc = '0;
    if (w_wb_wr) begin
      w_nxt_a3 = bus.wb_a3;
      w_nxt_wd = bus.wb_wd;
      w_nxt_pc = bus.wb_pc;
    end else if (w_pop && w_head.live) begin
      w_nxt_a3 = w_head.a3;
      w_nxt_wd = w_head.wd;
      w_nxt_pc = w_head.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grf_a3 <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end else begin
      r_grf_a3 <= w_nxt_a3;
      r_grf_wd <= w_nxt_wd;
      r_grf_pc <= w_nxt_pc;
    end
  end

`ifdef GRF_WRITER_TRACE_EN
  always @(posedge clk)
    if (!reset && (w_nxt_a3 != 5'd0))
      $display(`GRF_TRACE_FMT, w_nxt_pc, w_nxt_a3, w_nxt_wd);
`else
  // Trace disabled: no simulation-only logic in this build.
`endif

  assign bus.md_ready = w_rdy;
  assign bus.grf_a3   = r_grf_a3;
  assign bus.grf_wd   = r_grf_wd;
  assign bus.grf_pc   = r_grf_pc;
  assign bus.fifo_cnt = w_cnt;
endmodule

// File: tb/tb_w_grf_writer.sv
module tb_w_grf_writer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  w_grf_writer_if #(.DEPTH(2)) bus ();
  w_grf_writer #(.DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    string       nm;
    logic        rst;
    logic        wbv;
    logic [4:0]  wa;
    logic [31:0] ww, wp;
    logic        mdv;
    logic [4:0]  ma;
    logic [31:0] mw, mp;
    logic [4:0]  q1, q2;
    logic        er, eb1, eb2;
    logic [4:0]  ea;
    logic [31:0] ew, ep;
    logic [1:0]  ec;
  } vec_t;

  typedef struct {
    string       nm;
    logic [4:0]  a3;
    logic [31:0] wd, pc;
    logic [1:0]  cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(string nm, logic rst, logic wbv, logic [4:0] wa,
      logic [31:0] ww, logic [31:0] wp, logic mdv, logic [4:0] ma, logic [31:0] mw,
      logic [31:0] mp, logic [4:0] q1, logic [4:0] q2, logic er, logic eb1, logic eb2,
      logic [4:0] ea, logic [31:0] ew, logic [31:0] ep, logic [1:0] ec);
    vec_t t;
    t.nm = nm; t.rst = rst; t.wbv = wbv; t.wa = wa; t.ww = ww; t.wp = wp;
    t.mdv = mdv; t.ma = ma; t.mw = mw; t.mp = mp; t.q1 = q1; t.q2 = q2;
    t.er = er; t.eb1 = eb1; t.eb2 = eb2; t.ea = ea; t.ew = ew; t.ep = ep; t.ec = ec;
    return t;
  endfunction

  task automatic step(input vec_t t);
    exp_t e, g;
    reset        = t.rst;
    bus.wb_valid = t.wbv; bus.wb_a3 = t.wa; bus.wb_wd = t.ww; bus.wb_pc = t.wp;
    bus.md_valid = t.mdv; bus.md_a3 = t.ma; bus.md_wd = t.mw; bus.md_pc = t.mp;
    bus.q_a1     = t.q1;  bus.q_a2  = t.q2;
    e.nm = t.nm; e.a3 = t.ea; e.wd = t.ew; e.pc = t.ep; e.cnt = t.ec;
    sb.push_back(e);
    #1;
    chk({t.nm, ".md_ready"}, 32'(bus.md_ready), 32'(t.er));
    chk({t.nm, ".q_busy1"},  32'(bus.q_busy1),  32'(t.eb1));
    chk({t.nm, ".q_busy2"},  32'(bus.q_busy2),  32'(t.eb2));
    @(posedge clk); #1;
    g = sb.pop_front();
    chk({g.nm, ".grf_a3"},   32'(bus.grf_a3),   32'(g.a3));
    chk({g.nm, ".grf_wd"},   bus.grf_wd,        g.wd);
    chk({g.nm, ".grf_pc"},   bus.grf_pc,        g.pc);
    chk({g.nm, ".fifo_cnt"}, 32'(bus.fifo_cnt), 32'(g.cnt));
  endtask

  initial begin
    //          name   rst wbv wa  ww         wp         mdv ma  mw         mp         q1  q2  rdy b1 b2 ea  ew         ep         cnt
    tbl.push_back(v("md1",   0, 0, 0, 0,         0,         1, 5, 32'h11,   32'h3000,  5,  0,  1, 0, 0, 0, 0,         0,         1));
    tbl.push_back(v("md1d",  0, 0, 0, 0,         0,         0, 0, 0,        0,         5,  0,  1, 1, 0, 5, 32'h11,   32'h3000,  0));
    tbl.push_back(v("md1i",  0, 0, 0, 0,         0,         0, 0, 0,        0,         5,  0,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("bp0",   0, 1, 8, 32'h80,   32'h100,   1, 9, 32'h90,   32'h200,   9,  8,  1, 0, 0, 8, 32'h80,   32'h100,   1));
    tbl.push_back(v("bp1",   0, 1, 8, 32'h81,   32'h104,   1, 9, 32'h91,   32'h204,   9,  8,  1, 1, 0, 8, 32'h81,   32'h104,   2));
    tbl.push_back(v("bp2",   0, 1, 8, 32'h82,   32'h108,   1, 9, 32'h92,   32'h208,   9,  8,  0, 1, 0, 8, 32'h82,   32'h108,   2));
    tbl.push_back(v("bpd0",  0, 0, 0, 0,         0,         0, 0, 0,        0,         9,  8,  0, 1, 0, 9, 32'h90,   32'h200,   1));
    tbl.push_back(v("bpd1",  0, 0, 0, 0,         0,         0, 0, 0,        0,         9,  8,  1, 1, 0, 9, 32'h91,   32'h204,   0));
    tbl.push_back(v("bpd2",  0, 0, 0, 0,         0,         0, 0, 0,        0,         9,  8,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("kq",    0, 0, 0, 0,         0,         1, 4, 32'hAA,   32'h300,   4,  0,  1, 0, 0, 0, 0,         0,         1));
    tbl.push_back(v("kwb",   0, 1, 4, 32'hBB,   32'h304,   0, 0, 0,        0,         4,  0,  1, 1, 0, 4, 32'hBB,   32'h304,   1));
    tbl.push_back(v("kpop",  0, 0, 0, 0,         0,         0, 0, 0,        0,         4,  0,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("same7", 0, 1, 7, 32'h77,   32'h400,   1, 7, 32'h70,   32'h404,   7,  0,  1, 0, 0, 7, 32'h77,   32'h400,   0));
    tbl.push_back(v("same7i",0, 0, 0, 0,         0,         0, 0, 0,        0,         7,  0,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("md0",   0, 0, 0, 0,         0,         1, 0, 32'h55,   32'h500,   0,  0,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("md0i",  0, 0, 0, 0,         0,         0, 0, 0,        0,         0,  0,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("pp0",   0, 0, 0, 0,         0,         1, 1, 32'h1,    32'h10,    1,  2,  1, 0, 0, 0, 0,         0,         1));
    tbl.push_back(v("pp1",   0, 0, 0, 0,         0,         1, 2, 32'h2,    32'h14,    1,  2,  1, 1, 0, 1, 32'h1,    32'h10,    1));
    tbl.push_back(v("pp2",   0, 0, 0, 0,         0,         1, 3, 32'h3,    32'h18,    2,  3,  1, 1, 0, 2, 32'h2,    32'h14,    1));
    tbl.push_back(v("full",  0, 1, 6, 32'h66,   32'h500,   1, 10, 32'hA,   32'h1C,    3, 10,  1, 1, 0, 6, 32'h66,   32'h500,   2));
    tbl.push_back(v("fpop",  0, 0, 0, 0,         0,         1, 11, 32'hB,   32'h20,    3, 10,  0, 1, 1, 3, 32'h3,    32'h18,    1));
    tbl.push_back(v("fdr",   0, 0, 0, 0,         0,         0, 0, 0,        0,         3, 11,  1, 0, 0, 10, 32'hA,   32'h1C,    0));
    tbl.push_back(v("fidl",  0, 0, 0, 0,         0,         0, 0, 0,        0,         0,  0,  1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("wz0",   0, 0, 0, 0,         0,         1, 12, 32'hC,   32'h24,    12, 0,  1, 0, 0, 0, 0,         0,         1));
    tbl.push_back(v("wz1",   0, 1, 0, 32'hFF,   32'h28,    0, 0, 0,        0,         12, 0,  1, 1, 0, 12, 32'hC,   32'h24,    0));
    tbl.push_back(v("rs0",   0, 0, 0, 0,         0,         1, 13, 32'hD,   32'h600,   13, 14, 1, 0, 0, 0, 0,         0,         1));
    tbl.push_back(v("rs1",   0, 1, 6, 32'h67,   32'h604,   1, 14, 32'hE,   32'h608,   13, 14, 1, 1, 0, 6, 32'h67,   32'h604,   2));
    tbl.push_back(v("rsp",   1, 0, 0, 0,         0,         1, 15, 32'hF,   32'h60C,   13, 14, 0, 1, 1, 0, 0,         0,         0));
    tbl.push_back(v("rs2",   0, 0, 0, 0,         0,         0, 0, 0,        0,         13, 14, 1, 0, 0, 0, 0,         0,         0));
    tbl.push_back(v("rs3",   0, 0, 0, 0,         0,         0, 0, 0,        0,         13, 14, 1, 0, 0, 0, 0,         0,         0));

    // Power-on reset with md offered: must be ignored.
    reset = 1'b1;
    bus.wb_valid = 0; bus.wb_a3 = 0; bus.wb_wd = 0; bus.wb_pc = 0;
    bus.md_valid = 1; bus.md_a3 = 3; bus.md_wd = 32'h33; bus.md_pc = 32'h4;
    bus.q_a1 = 0; bus.q_a2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grf_a3",   32'(bus.grf_a3),   32'd0);
    chk("rst.grf_wd",   bus.grf_wd,        32'd0);
    chk("rst.fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
    reset = 1'b0; bus.md_valid = 0;
    #1;
    chk("rst.md_ready", 32'(bus.md_ready), 32'd1);

    foreach (tbl[i]) step(tbl[i]);

    // After the mid-drain reset, the discarded entries must never be written.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst.grf_a3", 32'(bus.grf_a3), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
